// File: rtl/x25519_mult121665_arbiter_pkg.sv
// Shared x25519 definitions: field-element width, modulus, arbiter FSM states
// and the round-robin pick helper.
package x25519_mult121665_arbiter_pkg;

  localparam int unsigned FE_W    = 264;
  localparam int unsigned MUL_K_W = 17;
  localparam logic [MUL_K_W-1:0] MUL_K = 17'd121665;

  // p = 2^255 - 19
  localparam logic [255:0] P25519 = {1'b0, {247{1'b1}}, 8'hED};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Lowest pending index at or after (last+1) mod n; n is at most 8.
  function automatic int unsigned rr_pick(input logic [7:0] pend,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    idx   = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (last + k) % n;
      if (!found && pend[idx[2:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/x25519_mult121665_arbiter_mult.sv
// Two-stage multiply-by-121665 modulo 2^255-19 on a 264-bit operand.
module X25519_Mult121665
  import x25519_mult121665_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [FE_W-1:0] a,
  output logic            out_valid,
  output logic [FE_W-1:0] out
);

  localparam int unsigned PROD_W = FE_W + MUL_K_W;

  logic [PROD_W-1:0] r_prod;
  logic              r_v1;
  logic              r_valid;
  logic [FE_W-1:0]   r_out;

  logic [255:0] w_fold1;
  logic [255:0] w_fold2;
  logic [255:0] w_sub;
  logic         w_ge;

  always_ff @(posedge clk) begin
    if (en) begin
      r_prod <= PROD_W'(a) * PROD_W'(MUL_K);
    end
  end

  // 2^255 == 19 (mod p): fold twice, then at most one subtraction of p.
  always_comb begin
    w_fold1 = 256'(r_prod[254:0]) + 256'(r_prod[PROD_W-1:255]) * 256'(19);
    w_fold2 = {1'b0, w_fold1[254:0]} + (w_fold1[255] ? 256'd19 : 256'd0);
    w_ge    = (w_fold2 >= P25519);
    w_sub   = w_fold2 - P25519;
  end

  always_ff @(posedge clk) begin
    if (r_v1) begin
      r_out <= FE_W'(w_ge ? w_sub : w_fold2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_v1    <= en;
      r_valid <= r_v1;
    end
  end

  assign out_valid = r_valid;
  assign out       = r_out;

endmodule

// File: rtl/x25519_mult121665_arbiter.sv
// Round-robin arbiter sharing one multiply-by-121665 unit among NUM_REQ
// requesters, each with a private operand buffer and pending flag.
module x25519_mult121665_arbiter
  import x25519_mult121665_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
)
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ-1:0][FE_W-1:0]  req_a,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [FE_W-1:0]               resp_out
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_pending;
  logic [NUM_REQ-1:0]  r_busy;
  logic [NUM_REQ-1:0]  r_err;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [FE_W-1:0]     r_resp_out;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_last;
  logic [FE_W-1:0]     r_buf [NUM_REQ];

  logic [NUM_REQ-1:0]  w_accept;
  logic [NUM_REQ-1:0]  w_done_mask;
  logic                w_done;
  logic                w_mul_en;
  logic [FE_W-1:0]     w_mul_a;
  logic                w_mul_valid;
  logic [FE_W-1:0]     w_mul_out;
  int unsigned         w_pick;

  assign w_accept    = req_en & ~r_busy;
  assign w_mul_en    = (r_state == ST_ISSUE);
  assign w_mul_a     = r_buf[r_owner];
  // out_valid only counts in WAIT; anything else is a stale pre-reset result.
  assign w_done      = (r_state == ST_WAIT) && w_mul_valid;
  assign w_done_mask = w_done ? (NUM_REQ'(1) << r_owner) : '0;
  assign w_pick      = rr_pick(8'(r_pending), 32'(r_last), NUM_REQ);

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_accept[i]) begin
        r_buf[i] <= req_a[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_busy       <= '0;
      r_err        <= '0;
      r_resp_valid <= '0;
      r_resp_out   <= '0;
      r_owner      <= '0;
      r_last       <= IW'(NUM_REQ - 1);
    end else begin
      r_err        <= req_en & r_busy;
      r_pending    <= (r_pending & ~w_done_mask) | w_accept;
      // busy drops one cycle after the response strobe, so a request on the
      // strobe edge itself is still rejected.
      r_busy       <= (r_busy & ~r_resp_valid) | w_accept;
      r_resp_valid <= w_done_mask;
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_owner <= IW'(w_pick);
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_mul_valid) begin
            r_resp_out <= w_mul_out;
            r_last     <= r_owner;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  X25519_Mult121665 u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_mul_en),
    .a         (w_mul_a),
    .out_valid (w_mul_valid),
    .out       (w_mul_out)
  );

  assign req_busy   = r_busy;
  assign req_err    = r_err;
  assign resp_valid = r_resp_valid;
  assign resp_out   = r_resp_out;

endmodule

// File: doc/x25519_mult121665_arbiter.md
X25519_MULT121665_ARBITER -- requirements
Module: x25519_mult121665_arbiter

Interface
REQ-001 The block SHALL have one parameter: NUM_REQ, default 4, the number of requesters sharing one multiply-by-121665 unit (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port req_en, input, NUM_REQ bits: per-requester single-cycle operation request.
REQ-005 The block SHALL have port req_a, input, NUM_REQ x 264 bits (packed array): per-requester operand, sampled only when the matching req_en bit is high.
REQ-006 The block SHALL have port req_busy, output, NUM_REQ bits: requester has an operation pending or in flight.
REQ-007 The block SHALL have port req_err, output, NUM_REQ bits: one-cycle pulse when a request is rejected.
REQ-008 The block SHALL have port resp_valid, output, NUM_REQ bits: one-cycle, one-hot result strobe.
REQ-009 The block SHALL have port resp_out, output, 264 bits: result, valid while any resp_valid bit is high.

Function
REQ-010 Each requester SHALL own one operand buffer (264 bits) and one pending flag.
REQ-011 A req_en[i] with req_busy[i] low SHALL capture req_a[i] and set pending[i] at that edge.
REQ-012 A req_en[i] with req_busy[i] high SHALL be dropped; req_err[i] pulses the next cycle; buffer unchanged.
REQ-013 req_busy[i] SHALL be registered: high from the cycle after acceptance until the cycle after resp_valid[i].
REQ-014 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-015 IDLE: if any pending bit is set, grant the lowest index at or after (last_grant+1) mod NUM_REQ, latch owner, go to ISSUE; else stay.
REQ-016 ISSUE: drive the multiplier en high for exactly one cycle with the owner's buffer as operand, then go to WAIT.
REQ-017 WAIT: on multiplier out_valid, register out into resp_out, pulse resp_valid[owner] next cycle, clear pending[owner], set last_grant to owner, go to IDLE.
REQ-018 Multiplier out_valid outside WAIT SHALL be ignored (stale result after reset).
REQ-019 At most one operation SHALL be in flight; the multiplier en SHALL never assert outside ISSUE.
REQ-020 Accepting a request for requester i SHALL be allowed in the same cycle another requester's result returns.
REQ-021 Requests for i arriving on the same edge that resp_valid[i] rises SHALL be rejected, because busy is still high.
REQ-022 Best-case latency from accepted req_en to resp_valid SHALL be 3 cycles plus the multiplier latency.
REQ-023 With all requesters permanently pending, grants SHALL rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 operations.

Reset
REQ-024 On rst_n low the block SHALL, asynchronously: enter IDLE; clear pending, req_busy, req_err and resp_valid; set last_grant to NUM_REQ-1; zero resp_out and owner.
REQ-025 Operand buffers SHALL need no reset.
REQ-026 Reset mid-operation SHALL discard all pending and in-flight work, with no resp_valid for it afterwards.

Structure
REQ-027 The FSM state enum and the 264-bit field-element width constant SHALL be defined in the shared x25519 package.
REQ-028 The block SHALL instantiate exactly one X25519_Mult121665 as its sole sub-module.

Verification
REQ-029 Single request: req_en[0], a=0x00dc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967 -> one resp_valid[0] pulse, resp_out=0x0076d50ea0922c309045e6245a73521e6b0d356b0063b42ea9400be160ed7a8950.
REQ-030 Simultaneous requests from all four requesters, same cycle, operands 0x00f1b1...3e70, 0x007dba...f705, 0x004efd...1a0b, 0x008620...d408:
- responses in order 0,1,2,3;
- results 0x0066025d...44a3, 0x004ab3f1...a4b5, 0x0024cda6...ca10, 0x000450d3...a3f5.
REQ-031 Double request: req_en[2] twice, 1 cycle apart -> req_err[2] pulses once; one resp_valid[2] carrying the first operand's result.
REQ-032 Fairness: requesters 0 and 1 re-request immediately after every response for 20 operations -> grants strictly alternate.
REQ-033 Reset while in WAIT:
- after reset, no resp_valid appears;
- all req_busy bits are 0;
- a new request then completes with the correct result.
